// File: rtl/lm35_link_tx_if.sv
// Handshake bus between the LM35 sample transmitter and its 3-bit chunk receiver.
interface lm35_link_tx_if;
    logic       start;
    logic [9:0] din;
    logic       back;
    logic [2:0] db;
    logic       ack;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, din, back,
        output db, ack, busy, done, err
    );

    modport slave (
        output start, din, back,
        input  db, ack, busy, done, err
    );
endinterface

// File: rtl/lm35_link_tx.sv
// Sends a clamped 10-bit temperature sample as four 3-bit chunks over a
// four-phase ack/back handshake, with a per-phase timeout abort.
module lm35_link_tx #(
    parameter int unsigned SETUP_CNT   = 16,
    parameter int unsigned TIMEOUT_CNT = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    lm35_link_tx_if.master     bus
);

    localparam int unsigned CNT_W   = 24;
    localparam int unsigned WORD_W  = 12;
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CNT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CNT - 1);
    localparam logic [9:0]       MAX_VAL      = 10'd999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_k, w_k_nxt;
    logic [WORD_W-1:0]  r_word, w_word_nxt;
    logic               r_back_meta, r_back_sync;
    logic [2:0]         r_db, w_db_nxt;
    logic               r_ack, r_busy, r_done, r_err;
    logic               w_done_nxt, w_err_nxt;
    logic [9:0]         w_clamped;

    function automatic logic [2:0] chunk_of(input logic [WORD_W-1:0] w, input logic [1:0] k);
        case (k)
            2'd0:    chunk_of = w[11:9];
            2'd1:    chunk_of = w[8:6];
            2'd2:    chunk_of = w[5:3];
            default: chunk_of = w[2:0];
        endcase
    endfunction

    assign w_clamped = (bus.din > MAX_VAL) ? MAX_VAL : bus.din;

    // back comes from another clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_back_meta <= 1'b0;
            r_back_sync <= 1'b0;
        end else begin
            r_back_meta <= bus.back;
            r_back_sync <= r_back_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_word  <= w_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_word_nxt  = r_word;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SETUP;
                    w_word_nxt  = {2'b00, w_clamped};
                    w_k_nxt     = 2'd0;
                    w_cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STROBE: begin
                // exit condition is tested before the timeout so it wins a tie
                if (r_back_sync) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!r_back_sync) begin
                    w_cnt_nxt = '0;
                    if (r_k == 2'd3) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = SETUP;
                        w_k_nxt     = r_k + 2'd1;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_db_nxt = (w_state_nxt == IDLE) ? 3'd0 : chunk_of(w_word_nxt, w_k_nxt);
    end

    // outputs registered from the next-state decode so they align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db   <= '0;
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_db   <= w_db_nxt;
            r_ack  <= (w_state_nxt == STROBE);
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign bus.db   = r_db;
    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_lm35_link_tx.sv
// Directed bench for lm35_link_tx with a receiver model answering ack one cycle late.
module tb_lm35_link_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lm35_link_tx_if bus();

    lm35_link_tx #(.SETUP_CNT(2), .TIMEOUT_CNT(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;          // 0 responsive, 1 back stuck 0, 2 back stuck 1
    logic [2:0] chunks[$];
    int n_done = 0, n_err = 0, n_both = 0, ack_cyc = 0;
    logic prev_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model plus frame monitor
    always @(negedge clk) begin
        case (mode)
            0:       bus.back = bus.ack;
            1:       bus.back = 1'b0;
            default: bus.back = 1'b1;
        endcase
        if (bus.ack === 1'b1 && prev_ack !== 1'b1) chunks.push_back(bus.db);
        prev_ack = bus.ack;
        if (bus.ack === 1'b1) ack_cyc++;
        if (bus.done === 1'b1) n_done++;
        if (bus.err === 1'b1) n_err++;
        if (bus.done === 1'b1 && bus.err === 1'b1) n_both++;
    end

    task automatic clr();
        chunks.delete();
        n_done = 0; n_err = 0; ack_cyc = 0;
    endtask

    task automatic start_frame(input logic [9:0] d);
        bus.din   = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && bus.busy === 1'b1; i++) @(negedge clk);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                             input logic [2:0] c2, input logic [2:0] c3);
        chk({tag, "_nchunk"}, 32'(chunks.size()), 32'd4);
        if (chunks.size() == 4) begin
            chk({tag, "_c0"}, 32'(chunks[0]), 32'(c0));
            chk({tag, "_c1"}, 32'(chunks[1]), 32'(c1));
            chk({tag, "_c2"}, 32'(chunks[2]), 32'(c2));
            chk({tag, "_c3"}, 32'(chunks[3]), 32'(c3));
        end
        chk({tag, "_done"}, 32'(n_done), 32'd1);
        chk({tag, "_err"}, 32'(n_err), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.din   = '0;
        bus.back  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_db",   32'(bus.db),   32'd0);
        chk("rst_ack",  32'(bus.ack),  32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 237 -> 000 011 101 101; first cycle after start shows chunk0 with ack low
        clr();
        start_frame(10'd237);
        chk("f237_busy", 32'(bus.busy), 32'd1);
        chk("f237_ack0", 32'(bus.ack),  32'd0);
        chk("f237_db0",  32'(bus.db),   32'd0);
        wait_idle("f237");
        chk_frame("f237", 3'b000, 3'b011, 3'b101, 3'b101);
        chk("f237_db_idle", 32'(bus.db), 32'd0);

        // 1023 clamps to 999 -> 001 111 100 111
        clr();
        start_frame(10'd1023);
        wait_idle("f1023");
        chk_frame("f1023", 3'b001, 3'b111, 3'b100, 3'b111);

        // back never answers: 20 ack cycles then err
        clr();
        mode = 1;
        start_frame(10'd237);
        wait_idle("to_strobe");
        chk("to_strobe_ackcyc", 32'(ack_cyc), 32'd20);
        chk("to_strobe_err",    32'(n_err),   32'd1);
        chk("to_strobe_done",   32'(n_done),  32'd0);
        chk("to_strobe_ack",    32'(bus.ack), 32'd0);
        chk("to_strobe_db",     32'(bus.db),  32'd0);
        mode = 0;
        repeat (4) @(negedge clk);

        // back stuck high: first chunk strobes once, RELEASE times out
        clr();
        mode = 2;
        start_frame(10'd237);
        wait_idle("to_rel");
        chk("to_rel_nchunk", 32'(chunks.size()), 32'd1);
        chk("to_rel_ackcyc", 32'(ack_cyc), 32'd1);
        chk("to_rel_err",    32'(n_err),   32'd1);
        chk("to_rel_done",   32'(n_done),  32'd0);
        mode = 0;
        repeat (4) @(negedge clk);

        // start re-pulsed mid-frame is ignored
        clr();
        start_frame(10'd237);
        repeat (6) @(negedge clk);
        start_frame(10'd5);
        wait_idle("restart");
        chk_frame("restart", 3'b000, 3'b011, 3'b101, 3'b101);

        // back-to-back: start in the done cycle is accepted
        clr();
        start_frame(10'd237);
        for (int i = 0; i < 400 && bus.done !== 1'b1; i++) @(negedge clk);
        chk("b2b_done_seen", 32'(bus.done), 32'd1);
        start_frame(10'd999);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_idle("b2b");
        chk("b2b_nchunk", 32'(chunks.size()), 32'd8);
        if (chunks.size() == 8) begin
            chk("b2b_c4", 32'(chunks[4]), 32'd1);
            chk("b2b_c5", 32'(chunks[5]), 32'd7);
            chk("b2b_c6", 32'(chunks[6]), 32'd4);
            chk("b2b_c7", 32'(chunks[7]), 32'd7);
        end
        chk("b2b_ndone", 32'(n_done), 32'd2);

        // reset during STROBE of chunk 2
        clr();
        start_frame(10'd237);
        for (int i = 0; i < 200 && chunks.size() < 3; i++) @(negedge clk);
        chk("rmid_in_strobe", 32'(bus.ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_ack",  32'(bus.ack),  32'd0);
        chk("rmid_db",   32'(bus.db),   32'd0);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rmid_wait_idle", 32'(bus.busy), 32'd0);
        chk("rmid_no_done",   32'(n_done),   32'd0);
        chk("rmid_no_err",    32'(n_err),    32'd0);
        clr();
        start_frame(10'd999);
        wait_idle("rpost");
        chk_frame("rpost", 3'b001, 3'b111, 3'b100, 3'b111);

        chk("never_both", 32'(n_both), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lm35_link_tx.md
LM35_LINK_TX -- requirements
Module: lm35_link_tx

Interface
REQ-001 Parameter SETUP_CNT, default 16: clk cycles db is stable before ack rises; legal range 1..65535.
REQ-002 Parameter TIMEOUT_CNT, default 1000000: clk cycles allowed per handshake phase before the frame aborts; legal range 1..2^24-1.
REQ-003 Port clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to send din; sampled only in IDLE.
REQ-006 Port din  input  10  unsigned temperature sample to transmit, in 0.1 degree units.
REQ-007 Port back  input  1  receiver acknowledge; asynchronous to clk.
REQ-008 Port db  output  3  chunk data bus to the receiver.
REQ-009 Port ack  output  1  chunk strobe to the receiver; high means db is valid.
REQ-010 Port busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-011 Port done  output  1  one-cycle pulse on successful frame completion.
REQ-012 Port err  output  1  one-cycle pulse on timeout abort.

Function
REQ-013 back SHALL pass through a 2-flop synchronizer; all references to back below mean the synchronized value.
REQ-014 When start=1 in IDLE, the block SHALL capture din, clamped to 999 if din>999, into a 12-bit word {2'b00, value}.
REQ-015 start while busy=1 SHALL be ignored, with no queuing.
REQ-016 A frame SHALL consist of 4 chunks sent MSB first: chunk k = word[11-3k : 9-3k], k=0..3.
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE and RELEASE.
REQ-018 IDLE -> SETUP on an accepted start; the next cycle SHALL show db=chunk0, ack=0, busy=1.
REQ-019 SETUP SHALL last exactly SETUP_CNT cycles with ack=0 and db stable, then go to STROBE.
REQ-020 STROBE: ack=1 and db held; when back=1 the FSM SHALL go to RELEASE, and ack SHALL be 0 from the next cycle.
REQ-021 RELEASE: ack=0 and db held; when back=0 the FSM SHALL go to SETUP with db=chunk k+1 if k<3, otherwise to IDLE with done=1 for one cycle.
REQ-022 A phase timer SHALL clear on entry to STROBE and to RELEASE; if it reaches TIMEOUT_CNT before the exit condition, the block SHALL go to IDLE with err=1 for one cycle and drive ack=0, db=0.
REQ-023 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win.
REQ-024 In IDLE: db=0, ack=0, busy=0; done and err SHALL never both be high.
REQ-025 A new start SHALL be accepted in the cycle after a done or err pulse, giving back-to-back frames.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, db=0, ack=0, busy=0, done=0, err=0, and clear the timer, chunk index, captured word and synchronizer.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done or err pulse; after rst_n rises the block SHALL wait in IDLE for a new start.

Verification (SETUP_CNT=2, TIMEOUT_CNT=20, responsive receiver model with 1-cycle back delay)
REQ-028 din=10'd237, start pulse -> db sequence 3'b000, 3'b011, 3'b101, 3'b101, each chunk preceded by a rising ack; then one done pulse and busy=0.
REQ-029 din=10'd1023 -> clamped to 999; chunks 3'b001, 3'b111, 3'b100, 3'b111; done pulse.
REQ-030 back held at 0 -> ack high for 20 cycles, then err pulse, ack=0, db=0, IDLE, no done.
REQ-031 back stuck at 1 after the first chunk -> RELEASE times out -> err pulse.
REQ-032 start re-pulsed mid-frame -> ignored; exactly one done pulse.
REQ-033 rst_n low during STROBE of chunk 2 -> ack=0, db=0 asynchronously; no pulses; a following start sends a full frame correctly.
